// File: rtl/echo_delay_line.sv
// echo_delay_line: stereo echo over an external single-port RAM, out = sat(dry + (delayed >>> decay_shift)).
// Define ECHO_FEEDBACK_EN to write the mixed sample back into the RAM (repeating echo); default writes the dry sample.
module echo_delay_line #(
  parameter int W      = 16,
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        left_in,
  input  logic [W-1:0]        right_in,
  input  logic [ADDR_W-1:0]   delay_len,
  input  logic [3:0]          decay_shift,
  output logic                out_valid,
  output logic [W-1:0]        left_out,
  output logic [W-1:0]        right_out,
  output logic [ADDR_W:0]     mem_addr,
  output logic [W-1:0]        mem_wdata,
  input  logic [W-1:0]        mem_rdata,
  output logic                mem_we
);
  localparam logic [2:0] IDLE = 3'd0, RDL = 3'd1, RDR = 3'd2, CAPR = 3'd3,
                         WRL  = 3'd4, WRR = 3'd5, OUTS = 3'd6;

  logic [2:0]               state_q, state_d;
  logic                     in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic signed [W-1:0]      dry_l_q, dry_l_d, dry_r_q, dry_r_d;
  logic signed [W-1:0]      d_l_q, d_l_d, d_r_q, d_r_d;
  logic signed [W-1:0]      left_out_q, left_out_d, right_out_q, right_out_d;
  logic [ADDR_W-1:0]        dlen_q, dlen_d, wr_ptr_q, wr_ptr_d, fill_q, fill_d;
  logic [3:0]               shift_q, shift_d;
  logic [ADDR_W:0]          mem_addr_q, mem_addr_d;
  logic [W-1:0]             mem_wdata_q, mem_wdata_d;
  logic                     accept, heard;
  logic [ADDR_W-1:0]        rd_ptr;
  logic signed [W-1:0]      mix_l, mix_r, wb_l, wb_r;

  function automatic logic signed [W-1:0] mix(input logic signed [W-1:0] dry,
                                              input logic signed [W-1:0] d,
                                              input logic en, input logic [3:0] sh);
    logic signed [W-1:0] wet;
    logic signed [W:0]   s;
    wet = d >>> sh;
    if (!en) wet = '0;
    s = dry + wet;
    return (s[W] != s[W-1]) ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
  endfunction

  assign accept = in_valid & in_ready_q;
  assign rd_ptr = wr_ptr_q - dlen_q;
  // Stale RAM (before this many samples were written since reset) must stay silent.
  assign heard  = (dlen_q != '0) && (fill_q >= dlen_q);
  assign mix_l  = mix(dry_l_q, d_l_q, heard, shift_q);
  assign mix_r  = mix(dry_r_q, d_r_q, heard, shift_q);
`ifdef ECHO_FEEDBACK_EN
  assign wb_l = mix_l;
  assign wb_r = mix_r;
`else
  assign wb_l = dry_l_q;
  assign wb_r = dry_r_q;
`endif

  always_comb begin
    state_d     = (state_q == IDLE) ? (accept ? RDL : IDLE) : (state_q == OUTS) ? IDLE : state_q + 3'd1;
    in_ready_d  = (state_d == IDLE);
    dry_l_d     = accept ? left_in : dry_l_q;
    dry_r_d     = accept ? right_in : dry_r_q;
    dlen_d      = accept ? delay_len : dlen_q;
    shift_d     = accept ? decay_shift : shift_q;
    d_l_d       = (state_q == RDR) ? mem_rdata : d_l_q;
    d_r_d       = (state_q == CAPR) ? mem_rdata : d_r_q;
    out_valid_d = (state_q == OUTS);
    left_out_d  = (state_q == OUTS) ? mix_l : left_out_q;
    right_out_d = (state_q == OUTS) ? mix_r : right_out_q;
    wr_ptr_d    = (state_q == OUTS) ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_d      = (state_q == OUTS && fill_q != '1) ? fill_q + 1'b1 : fill_q;
    mem_addr_d  = (state_q == RDL) ? {rd_ptr, 1'b0} :
                  (state_q == RDR) ? {rd_ptr, 1'b1} :
                  (state_q == WRL) ? {wr_ptr_q, 1'b0} :
                  (state_q == WRR) ? {wr_ptr_q, 1'b1} : mem_addr_q;
    mem_wdata_d = (state_q == WRL) ? wb_l : (state_q == WRR) ? wb_r : mem_wdata_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dry_l_q     <= '0;
      dry_r_q     <= '0;
      d_l_q       <= '0;
      d_r_q       <= '0;
      dlen_q      <= '0;
      shift_q     <= '0;
      left_out_q  <= '0;
      right_out_q <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dry_l_q     <= dry_l_d;
      dry_r_q     <= dry_r_d;
      d_l_q       <= d_l_d;
      d_r_q       <= d_r_d;
      dlen_q      <= dlen_d;
      shift_q     <= shift_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign left_out  = left_out_q;
  assign right_out = right_out_q;
  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;
  assign mem_we    = (state_q == WRL) || (state_q == WRR);
endmodule
